display_text_buffer: RTL

Parametrised character buffer between the host text/UART front end and the HPDL-1414 scan-out logic. It holds DEPTH characters and maintains a write cursor. Printable writes, backspace and clear are handled in hardware, with either scroll-left or wrap-around at the end of the line. The scan-out side reads characters through a registered port, and the cell under the cursor is replaced by a blinking caret.

---
 rtl/display_text_buffer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/display_text_buffer.sv
// display_text_buffer
//   Character buffer between the host text front end and the HPDL-1414
//   scan-out. It holds DEPTH cells and a write cursor, and handles printable
//   writes, backspace and clear. At the end of the line it either scrolls left
//   (WRAP_MODE = 0) or wraps the cursor to 0 (WRAP_MODE = 1). Scan-out reads
//   go through a registered port. When enabled, the cell under the cursor reads
//   back as a blinking caret.
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_char_valid/_data    write a character at the cursor
//   i_bksp, i_clear       backspace / clear-screen commands
//   o_ready               commands accepted (FSM idle)
//   i_rd_en, i_rd_addr    read request; o_rd_data valid one cycle later
//   i_caret_en            enable caret substitution on reads
//   o_cursor, o_full      cursor position; last cell occupied (scroll mode)
module display_text_buffer #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            DEPTH      = 16,
  parameter int unsigned            ADDR_W     = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0]  CARET_CHR  = 8'h5F,
  parameter logic [DATA_WIDTH-1:0]  BLANK_CHR  = 8'h20,
  parameter int unsigned            BLINK_DIV  = 6_000_000,
  parameter int unsigned            WRAP_MODE  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_char_valid,
  input  logic [DATA_WIDTH-1:0] i_char_data,
  input  logic                  i_bksp,
  input  logic                  i_clear,
  output logic                  o_ready,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_caret_en,
  output logic [ADDR_W-1:0]     o_cursor,
  output logic                  o_full
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam int unsigned       CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                r_state;
  logic [ADDR_W-1:0]     r_clr_idx;
  logic [ADDR_W-1:0]     r_cursor;
  logic                  r_full;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [CNT_W-1:0]      r_blink_cnt;
  logic                  r_phase;

  logic w_idle;
  logic w_do_bksp;
  logic w_do_char;
  logic w_at_end;
  logic w_shift;
  logic w_rd_oor;

  // Decoded commands with priority clear > backspace > character.
  assign w_idle    = (r_state == StIdle);
  assign w_do_bksp = w_idle & ~i_clear & i_bksp;
  assign w_do_char = w_idle & ~i_clear & ~i_bksp & i_char_valid;
  assign w_at_end  = (r_cursor == LAST);
  assign w_shift   = w_do_char & w_at_end & r_full & (WRAP_MODE == 0);
  // Widened so a non-power-of-two DEPTH still catches out-of-range reads.
  assign w_rd_oor  = ({1'b0, i_rd_addr} >= (ADDR_W + 1)'(DEPTH));

  // Control FSM: clear sweep, cursor and full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
      r_cursor  <= '0;
      r_full    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      unique case (r_state)
        StClear: begin
          if (r_clr_idx == LAST) begin
            r_state   <= StIdle;
            r_ready   <= 1'b1;
            r_clr_idx <= '0;
            r_cursor  <= '0;
            r_full    <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + ADDR_W'(1);
          end
        end
        StIdle: begin
          if (i_clear) begin
            r_state   <= StClear;
            r_ready   <= 1'b0;
            r_clr_idx <= '0;
          end else if (i_bksp) begin
            // A full line backspaces over the last cell without moving the cursor.
            if (r_full) begin
              r_full <= 1'b0;
            end else if (r_cursor != '0) begin
              r_cursor <= r_cursor - ADDR_W'(1);
            end
          end else if (i_char_valid) begin
            if (!w_at_end) begin
              r_cursor <= r_cursor + ADDR_W'(1);
            end else if (WRAP_MODE != 0) begin
              r_cursor <= '0;
            end else begin
              r_full <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= StClear;
          r_ready   <= 1'b0;
          r_clr_idx <= '0;
        end
      endcase
    end
  end

  // Cell array, intentionally not reset; the clear sweep initialises it.
  always_ff @(posedge i_clk) begin
    if (r_state == StClear) begin
      r_mem[r_clr_idx] <= BLANK_CHR;
    end else if (w_do_bksp) begin
      if (r_full) begin
        r_mem[LAST] <= BLANK_CHR;
      end else if (r_cursor != '0) begin
        r_mem[r_cursor - ADDR_W'(1)] <= BLANK_CHR;
      end
    end else if (w_do_char) begin
      if (w_shift) begin
        for (int k = 0; k < int'(DEPTH) - 1; k++) begin
          r_mem[k] <= r_mem[k+1];
        end
        r_mem[LAST] <= i_char_data;
      end else begin
        r_mem[r_cursor] <= i_char_data;
      end
    end
  end

  // Caret blink timer and registered read port (read-before-write).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (r_blink_cnt == CNT_MAX) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
      if (i_rd_en) begin
        if (!w_idle || w_rd_oor) begin
          r_rd_data <= BLANK_CHR;
        end else if (i_caret_en && r_phase && (i_rd_addr == r_cursor)) begin
          r_rd_data <= CARET_CHR;
        end else begin
          r_rd_data <= r_mem[i_rd_addr];
        end
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_rd_data = r_rd_data;
  assign o_cursor  = r_cursor;
  assign o_full    = r_full;

endmodule
